// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC.
// Converts a Q2.30 vector (x_in, y_in), x_in >= 0, into a Q2.30 radian angle
// atan(y/x) and a saturated magnitude, one micro-rotation per clock.
// Optional gain compensation is enabled by defining CORDIC_GAIN_COMP_EN; it adds
// a COMP state that scales the raw magnitude by K = 0.6072529.
module cordic_vectoring #(
   parameter int ITER = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] x_in,
   input  logic [31:0] y_in,
   output logic [31:0] angle_out,
   output logic [31:0] mag_out,
   output logic        range_err,
   output logic        busy,
   output logic        done
);

   // Working width: Q2.30 plus three guard bits so the CORDIC gain (~1.65)
   // and the sqrt(2) growth of a full-scale diagonal vector never overflow.
   localparam int XW = 35;
   localparam logic signed [XW-1:0] MAG_MAX = 35'sh07FFFFFFF;

`ifdef CORDIC_GAIN_COMP_EN
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ITER  = 2'd1,
      S_COMP  = 2'd2,
      S_FINAL = 2'd3
   } state_t;
   localparam logic signed [31:0] K_GAIN = 32'sh26DD3B6A;
`else
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ITER  = 2'd1,
      S_FINAL = 2'd2
   } state_t;
`endif

   state_t                 state_reg, state_next;
   logic signed [XW-1:0]   x_reg, x_next;
   logic signed [XW-1:0]   y_reg, y_next;
   logic signed [31:0]     z_reg, z_next;
   logic [4:0]             i_reg, i_next;
   logic                   err_reg, err_next;
   logic                   zero_reg, zero_next;
   logic [31:0]            angle_reg, angle_next;
   logic [31:0]            mag_reg, mag_next;
   logic                   range_err_reg, range_err_next;
   logic                   busy_reg, busy_next;
   logic                   done_reg, done_next;

   // atan(2^-i) in Q2.30, rounded to nearest. Beyond i = 11 the cubic term
   // is below half an LSB, so the entries are exact powers of two.
   function automatic logic [31:0] atan_lut(input logic [4:0] idx);
      logic [31:0] v;
      case (idx)
         5'd0:    v = 32'h3243F6A9;
         5'd1:    v = 32'h1DAC6705;
         5'd2:    v = 32'h0FADBAFD;
         5'd3:    v = 32'h07F56EA7;
         5'd4:    v = 32'h03FEAB77;
         5'd5:    v = 32'h01FFD55C;
         5'd6:    v = 32'h00FFFAAB;
         5'd7:    v = 32'h007FFF55;
         5'd8:    v = 32'h003FFFEB;
         5'd9:    v = 32'h001FFFFD;
         5'd10:   v = 32'h00100000;
         5'd11:   v = 32'h00080000;
         5'd12:   v = 32'h00040000;
         5'd13:   v = 32'h00020000;
         5'd14:   v = 32'h00010000;
         5'd15:   v = 32'h00008000;
         5'd16:   v = 32'h00004000;
         5'd17:   v = 32'h00002000;
         5'd18:   v = 32'h00001000;
         5'd19:   v = 32'h00000800;
         5'd20:   v = 32'h00000400;
         5'd21:   v = 32'h00000200;
         5'd22:   v = 32'h00000100;
         5'd23:   v = 32'h00000080;
         5'd24:   v = 32'h00000040;
         5'd25:   v = 32'h00000020;
         5'd26:   v = 32'h00000010;
         5'd27:   v = 32'h00000008;
         5'd28:   v = 32'h00000004;
         5'd29:   v = 32'h00000002;
         default: v = 32'h00000000;
      endcase
      return v;
   endfunction

   // Clamp the working magnitude into the 31-bit positive output range.
   function automatic logic [31:0] sat_mag(input logic signed [XW-1:0] v);
      logic [31:0] r;
      if (v[XW-1]) begin
         r = 32'd0;
      end else if (v > MAG_MAX) begin
         r = 32'h7FFF_FFFF;
      end else begin
         r = v[31:0];
      end
      return r;
   endfunction

`ifdef CORDIC_GAIN_COMP_EN
   // Full-width signed product; the Q2.30 result is the product shifted by 30.
   logic signed [XW+31:0] prod;
   assign prod = (XW+32)'(x_reg) * (XW+32)'(K_GAIN);
`endif

   // Next-state and datapath logic for the control FSM.
   always_comb begin
      state_next     = state_reg;
      x_next         = x_reg;
      y_next         = y_reg;
      z_next         = z_reg;
      i_next         = i_reg;
      err_next       = err_reg;
      zero_next      = zero_reg;
      angle_next     = angle_reg;
      mag_next       = mag_reg;
      range_err_next = range_err_reg;
      busy_next      = busy_reg;
      done_next      = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               busy_next = 1'b1;
               z_next    = 32'sd0;
               i_next    = 5'd0;
               zero_next = (x_in == 32'd0) && (y_in == 32'd0);
               if (x_in[31]) begin
                  // Left half-plane is out of range: report zero result.
                  err_next   = 1'b1;
                  x_next     = '0;
                  y_next     = '0;
                  state_next = S_FINAL;
               end else begin
                  err_next   = 1'b0;
                  x_next     = {{(XW-32){x_in[31]}}, x_in};
                  y_next     = {{(XW-32){y_in[31]}}, y_in};
                  state_next = S_ITER;
               end
            end
         end

         S_ITER: begin
            // Rotate toward the x axis; both updates use the old x and y.
            if (!y_reg[XW-1]) begin
               x_next = x_reg + (y_reg >>> i_reg);
               y_next = y_reg - (x_reg >>> i_reg);
               z_next = z_reg + $signed(atan_lut(i_reg));
            end else begin
               x_next = x_reg - (y_reg >>> i_reg);
               y_next = y_reg + (x_reg >>> i_reg);
               z_next = z_reg - $signed(atan_lut(i_reg));
            end
            i_next = i_reg + 5'd1;
            if (i_reg == 5'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
               state_next = S_COMP;
`else
               state_next = S_FINAL;
`endif
            end
         end

`ifdef CORDIC_GAIN_COMP_EN
         S_COMP: begin
            x_next     = XW'(prod >>> 30);
            state_next = S_FINAL;
         end
`endif

         S_FINAL: begin
            // A zero vector never drives y negative, so z would collect every
            // table entry; report angle 0 for it instead.
            angle_next     = zero_reg ? 32'd0 : z_reg;
            mag_next       = sat_mag(x_reg);
            range_err_next = err_reg;
            done_next      = 1'b1;
            busy_next      = 1'b0;
            state_next     = S_IDLE;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any in-flight operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         x_reg         <= '0;
         y_reg         <= '0;
         z_reg         <= '0;
         i_reg         <= '0;
         err_reg       <= 1'b0;
         zero_reg      <= 1'b0;
         angle_reg     <= '0;
         mag_reg       <= '0;
         range_err_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         x_reg         <= x_next;
         y_reg         <= y_next;
         z_reg         <= z_next;
         i_reg         <= i_next;
         err_reg       <= err_next;
         zero_reg      <= zero_next;
         angle_reg     <= angle_next;
         mag_reg       <= mag_next;
         range_err_reg <= range_err_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
      end
   end

   assign angle_out = angle_reg;
   assign mag_out   = mag_reg;
   assign range_err = range_err_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Testbench for cordic_vectoring: directed table, random vectors against a
// real-arithmetic atan2/hypot model, and protocol sequences.
module tb_cordic_vectoring;

   localparam int ITER = 30;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int  LAT  = ITER + 2;
   localparam real GAIN = 1.0;
`else
   localparam int  LAT  = ITER + 1;
   localparam real GAIN = 1.6467602581210654;
`endif
   localparam real TWO30       = 1073741824.0;
   localparam int  ANG_TOL_DIR = 8;
   localparam int  MAG_TOL_DIR = 32;
   localparam int  ANG_TOL_RND = 64;
   localparam int  MAG_TOL_RND = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] x_in;
   logic [31:0] y_in;
   logic [31:0] angle_out;
   logic [31:0] mag_out;
   logic        range_err;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      logic [31:0] x;
      logic [31:0] y;
      longint      ang;
      longint      mag;
      bit          err;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   cordic_vectoring #(.ITER(ITER)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .x_in      (x_in),
      .y_in      (y_in),
      .angle_out (angle_out),
      .mag_out   (mag_out),
      .range_err (range_err),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_tol(input string name, input longint act, input longint exp, input longint tol);
      longint d;
      n_checks++;
      d = act - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%08h), want %0d +/- %0d", name, act, act[31:0], exp, tol);
      end
   endtask

   // Reference: polar conversion by plain real arithmetic.
   function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                 output longint ang, output longint mag, output bit err);
      real xr, yr, m;
      ang = 0;
      mag = 0;
      err = 1'b0;
      if (x[31]) begin
         err = 1'b1;
      end else if (x != 32'd0 || y != 32'd0) begin
         xr  = $itor($signed(x));
         yr  = $itor($signed(y));
         ang = longint'($atan2(yr, xr) * TWO30);
         m   = $sqrt(xr * xr + yr * yr) * GAIN;
         if (m > 2147483647.0) m = 2147483647.0;
         mag = longint'(m);
      end
   endfunction

   // Issue one start and wait (bounded) for done. gap=0 drives start in the
   // current cycle, which is the done cycle of a preceding operation.
   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit gap,
                         output logic [31:0] ang, output logic [31:0] mag, output bit err,
                         output int lat, output bit busy_seen, output bit busy_at_done);
      if (gap) @(negedge clk);
      x_in  = x;
      y_in  = y;
      start = 1'b1;
      @(posedge clk);
      #1;
      start        = 1'b0;
      busy_seen    = busy;
      busy_at_done = 1'b1;
      lat          = -1;
      ang          = '0;
      mag          = '0;
      err          = 1'b0;
      for (int c = 1; c <= LAT + 8; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat          = c;
            ang          = angle_out;
            mag          = mag_out;
            err          = range_err;
            busy_at_done = busy;
            break;
         end
      end
   endtask

   task automatic check_result(input string tag, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] ang, input logic [31:0] mag, input bit err,
                               input int lat, input bit bs, input bit bd,
                               input longint eang, input longint emag, input bit eerr,
                               input int atol, input int mtol);
      int elat;
      elat = eerr ? 1 : LAT;
      $display("op %s x=%08h y=%08h angle=%08h mag=%08h err=%0b lat=%0d", tag, x, y, ang, mag, err, lat);
      check_tol({tag, " latency"}, longint'(lat), longint'(elat), 0);
      check_tol({tag, " busy_after_start"}, longint'(bs), 1, 0);
      check_tol({tag, " busy_at_done"}, longint'(bd), 0, 0);
      check_tol({tag, " range_err"}, longint'(err), longint'(eerr), 0);
      check_tol({tag, " angle"}, longint'($signed(ang)), eang, atol);
      check_tol({tag, " mag"}, longint'(mag), emag, mtol);
   endtask

   initial begin
      logic [31:0] ang, mag, rx, ry;
      bit          err, bs, bd;
      int          lat, pulses;
      longint      eang, emag;
      bit          eerr;

      reset = 1'b1;
      start = 1'b0;
      x_in  = '0;
      y_in  = '0;
      repeat (3) @(posedge clk);
      #1;
      check_tol("reset angle_out", longint'(angle_out), 0, 0);
      check_tol("reset mag_out", longint'(mag_out), 0, 0);
      check_tol("reset range_err", longint'(range_err), 0, 0);
      check_tol("reset busy", longint'(busy), 0, 0);
      check_tol("reset done", longint'(done), 0, 0);
      @(negedge clk);
      reset = 1'b0;

      // Directed table: explicit angles, magnitudes from the gain setting.
      vecs[0] = '{"unit_x",   32'h40000000, 32'h00000000, 0,           longint'(GAIN * TWO30), 1'b0};
      vecs[1] = '{"diag_pos", 32'h20000000, 32'h20000000, 843314857,   longint'(GAIN * $sqrt(2.0) * 536870912.0), 1'b0};
      vecs[2] = '{"diag_neg", 32'h20000000, 32'hE0000000, -843314857,  longint'(GAIN * $sqrt(2.0) * 536870912.0), 1'b0};
      vecs[3] = '{"neg_x",    32'h80000000, 32'h12345678, 0,           0, 1'b1};
      vecs[4] = '{"sat_diag", 32'h7FFFFFFF, 32'h7FFFFFFF, 843314857,   2147483647, 1'b0};
      vecs[5] = '{"zero",     32'h00000000, 32'h00000000, 0,           0, 1'b0};
      vecs[6] = '{"pos_y",    32'h00000000, 32'h40000000, 1686629713,  longint'(GAIN * TWO30), 1'b0};
      vecs[7] = '{"neg_y",    32'h00000000, 32'hC0000000, -1686629713, longint'(GAIN * TWO30), 1'b0};

      for (int k = 0; k < 8; k++) begin
         run_op(vecs[k].x, vecs[k].y, 1'b1, ang, mag, err, lat, bs, bd);
         check_result(vecs[k].tag, vecs[k].x, vecs[k].y, ang, mag, err, lat, bs, bd,
                      vecs[k].ang, vecs[k].mag, vecs[k].err, ANG_TOL_DIR, MAG_TOL_DIR);
         @(posedge clk);
         #1;
         check_tol({vecs[k].tag, " done_width"}, longint'(done), 0, 0);
      end

      // Random vectors against the model; some with negative x.
      for (int k = 0; k < 30; k++) begin
         rx = 32'($urandom_range(32'h7FFFFFFF, 32'h10000000));
         ry = $urandom;
         if ($urandom_range(5, 0) == 0) rx = rx | 32'h80000000;
         model(rx, ry, eang, emag, eerr);
         run_op(rx, ry, 1'b1, ang, mag, err, lat, bs, bd);
         check_result($sformatf("rnd%0d", k), rx, ry, ang, mag, err, lat, bs, bd,
                      eang, emag, eerr, ANG_TOL_RND, MAG_TOL_RND);
      end

      // start while busy: a second start 5 cycles in is ignored.
      @(negedge clk);
      x_in  = 32'h40000000;
      y_in  = 32'h00000000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      x_in  = 32'h20000000;
      y_in  = 32'hE0000000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      pulses = 0;
      lat    = -1;
      for (int c = 6; c <= LAT + 20; c++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulses++;
            if (lat < 0) begin
               lat = c;
               ang = angle_out;
            end
         end
      end
      $display("op busy_start pulses=%0d lat=%0d angle=%08h", pulses, lat, ang);
      check_tol("busy_start pulses", longint'(pulses), 1, 0);
      check_tol("busy_start latency", longint'(lat), longint'(LAT), 0);
      check_tol("busy_start angle", longint'($signed(ang)), 0, ANG_TOL_DIR);

      // Back-to-back: start driven in the done cycle of the previous op.
      model(32'h40000000, 32'h40000000, eang, emag, eerr);
      run_op(32'h40000000, 32'h40000000, 1'b1, ang, mag, err, lat, bs, bd);
      check_result("b2b_first", 32'h40000000, 32'h40000000, ang, mag, err, lat, bs, bd,
                   eang, emag, eerr, ANG_TOL_DIR, MAG_TOL_DIR);
      model(32'h40000000, 32'hC0000000, eang, emag, eerr);
      run_op(32'h40000000, 32'hC0000000, 1'b0, ang, mag, err, lat, bs, bd);
      check_result("b2b_second", 32'h40000000, 32'hC0000000, ang, mag, err, lat, bs, bd,
                   eang, emag, eerr, ANG_TOL_DIR, MAG_TOL_DIR);

      // Reset 10 cycles into an operation: outputs clear, no done.
      @(negedge clk);
      x_in  = 32'h30000000;
      y_in  = 32'h10000000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_tol("midreset angle_out", longint'(angle_out), 0, 0);
      check_tol("midreset mag_out", longint'(mag_out), 0, 0);
      check_tol("midreset range_err", longint'(range_err), 0, 0);
      check_tol("midreset busy", longint'(busy), 0, 0);
      pulses = 0;
      repeat (LAT + 10) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      $display("op mid_reset pulses=%0d", pulses);
      check_tol("midreset done pulses", longint'(pulses), 0, 0);

      // start and reset together: reset wins, start dropped.
      @(negedge clk);
      x_in  = 32'h40000000;
      y_in  = 32'h00000000;
      start = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      reset = 1'b0;
      check_tol("reset_start busy", longint'(busy), 0, 0);
      pulses = 0;
      repeat (LAT + 5) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      $display("op reset_start pulses=%0d", pulses);
      check_tol("reset_start done pulses", longint'(pulses), 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
